// File: rtl/inst_buffer_loadable.sv
// inst_buffer_loadable: writable per-PE instruction buffer with an internal PC, loop count and done pulse.
module inst_buffer_loadable #(
    parameter int addrLen = 5,
    parameter int dataLen = 32,
    parameter int iterLen = 16,
    parameter int peId    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ldValid,
    input  logic [dataLen-1:0] ldData,
    input  logic               ldLast,
    output logic               ldReady,
    input  logic               start,
    input  logic [iterLen-1:0] numIter,
    input  logic               noStall,
    output logic [dataLen-1:0] dataOut,
    output logic               instValid,
    output logic [addrLen-1:0] pc,
    output logic               busy,
    output logic               done,
    output logic [addrLen:0]   progLen
);
    localparam int DEPTH = 1 << addrLen;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [dataLen-1:0] mem [DEPTH];
    logic [0:0]         state_q, state_d;
    logic [dataLen-1:0] data_q, data_d;
    logic               valid_q, valid_d;
    logic [addrLen-1:0] pc_q, pc_d;
    logic [addrLen-1:0] wr_ptr_q, wr_ptr_d;
    logic [iterLen-1:0] iter_q, iter_d;
    logic [addrLen:0]   prog_len_q, prog_len_d;
    logic               loaded_q, loaded_d;
    logic               done_q, done_d;
    logic               accept, last_beat, last_pc, go;

    assign ldReady   = state_q == IDLE;
    assign busy      = state_q == RUN;
    assign dataOut   = data_q;
    assign instValid = valid_q;
    assign pc        = pc_q;
    assign done      = done_q;
    assign progLen   = prog_len_q;

    assign accept    = ldValid && ldReady;
    // A full buffer closes the program so the pointer never wraps into address 0.
    assign last_beat = ldLast || (&wr_ptr_q);
    assign last_pc   = {1'b0, pc_q} == prog_len_q - 1'b1;
    assign go        = ldReady && start && !accept && loaded_q && (numIter != '0);

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        valid_d    = valid_q;
        pc_d       = pc_q;
        wr_ptr_d   = wr_ptr_q;
        iter_d     = iter_q;
        prog_len_d = prog_len_q;
        loaded_d   = loaded_q;
        done_d     = 1'b0;
        if (accept) begin
            wr_ptr_d   = last_beat ? '0 : wr_ptr_q + 1'b1;
            prog_len_d = last_beat ? {1'b0, wr_ptr_q} + 1'b1 : prog_len_q;
            loaded_d   = loaded_q || last_beat;
        end
        if (go) begin
            state_d = RUN;
            pc_d    = '0;
            iter_d  = numIter;
        end
        if (noStall && state_q == IDLE) valid_d = 1'b0;
        if (noStall && state_q == RUN) begin
            data_d  = mem[pc_q];
            valid_d = 1'b1;
            pc_d    = last_pc ? '0 : pc_q + 1'b1;
            if (last_pc && iter_q > iterLen'(1)) iter_d = iter_q - 1'b1;
            if (last_pc && iter_q <= iterLen'(1)) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr_q] <= ldData;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            data_q     <= '0;
            valid_q    <= 1'b0;
            pc_q       <= '0;
            wr_ptr_q   <= '0;
            iter_q     <= '0;
            prog_len_q <= '0;
            loaded_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            wr_ptr_q   <= wr_ptr_d;
            iter_q     <= iter_d;
            prog_len_q <= prog_len_d;
            loaded_q   <= loaded_d;
            done_q     <= done_d;
        end
    end
endmodule
